// File: rtl/api_define.sv
// Shared definitions for the API bus master: register map, STATE word layout,
// FSM encoding and the TX credit helper.
package api_define;

  localparam logic [5:0] ADR_TXFIFO  = 6'h00;
  localparam logic [5:0] ADR_RXFIFO  = 6'h04;
  localparam logic [5:0] ADR_STATE   = 6'h08;
  localparam logic [5:0] ADR_TIMEOUT = 6'h0c;
  localparam logic [5:0] ADR_SCK     = 6'h10;

  localparam logic [31:0] FLUSH_WORD = 32'h0000_0002;

  typedef struct packed {
    logic [2:0] rsv_hi;
    logic [8:0] rxcnt;
    logic [2:0] rsv_mid;
    logic       rxempty;
    logic [2:0] reg_state;
    logic       rsv_lo;
    logic [9:0] txcnt;
    logic       flush;
    logic       txfull;
  } state_word_t;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG_TO, S_CFG_SCK, S_FLUSH, S_POLL, S_RX, S_TX, S_GAP
  } fsm_t;

  // Free TXFIFO slots; clamps to zero if the slave reports more than depth.
  function automatic logic [9:0] calc_tx_credit(input state_word_t sw,
                                                input int unsigned depth);
    logic [10:0] d;
    d = 11'(depth);
    if (sw.txfull || ({1'b0, sw.txcnt} >= d)) return '0;
    return 10'(d - {1'b0, sw.txcnt});
  endfunction

endpackage

// File: rtl/api_master_watchdog.sv
// ACK-timeout counter: armed on each bus issue, disarmed on termination,
// flags expiry on the last allowed STB cycle.
module api_master_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic          run;
  logic [CW-1:0] cnt;

  assign expired = run && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
    end else if (run) begin
      if (expired) run <= 1'b0;
      else         cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/api_master.sv
// Wishbone initiator feeding the API register block: pushes work into TXFIFO,
// drains RXFIFO into the nonce stream, and issues config/flush writes.
module api_master
  import api_define::*;
#(
  parameter int TX_DEPTH    = 512,
  parameter int ACK_TIMEOUT = 15,
  parameter int POLL_GAP    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        API_CYC_O,
  output logic        API_STB_O,
  output logic        API_WE_O,
  output logic [5:0]  API_ADR_O,
  output logic [31:0] API_DAT_O,
  output logic [3:0]  API_SEL_O,
  output logic [2:0]  API_CTI_O,
  output logic [1:0]  API_BTE_O,
  output logic        API_LOCK_O,
  input  logic        API_ACK_I,
  input  logic        API_ERR_I,
  input  logic        API_RTY_I,
  input  logic [31:0] API_DAT_I,
  input  logic        work_valid,
  output logic        work_ready,
  input  logic [31:0] work_data,
  output logic        nonce_valid,
  input  logic        nonce_ready,
  output logic [31:0] nonce_data,
  input  logic        cfg_req,
  input  logic [24:0] cfg_timeout,
  input  logic [31:0] cfg_sck,
  input  logic        flush_req,
  output logic        bus_err,
  output logic [31:0] api_state
);

  fsm_t        state;
  logic        wait_ph;
  logic        stb;
  logic        we;
  logic [5:0]  adr;
  logic [31:0] dat_o;
  logic [8:0]  rx_credit;
  logic [9:0]  tx_credit;
  logic        consumed;
  logic        flush_pend;
  logic        cfg_pend;
  logic [24:0] cfg_to_q;
  logic [31:0] cfg_sck_q;
  logic [7:0]  gap_cnt;
  logic        rx_go, tx_go, issue, term, wd_expired;
  state_word_t rd_sw;
  logic        unused_rty;

  assign unused_rty = API_RTY_I;
  assign rd_sw      = state_word_t'(API_DAT_I);

  assign API_CYC_O  = stb;
  assign API_STB_O  = stb;
  assign API_WE_O   = we;
  assign API_ADR_O  = adr;
  assign API_DAT_O  = dat_o;
  assign API_SEL_O  = 4'hf;
  assign API_CTI_O  = 3'b000;
  assign API_BTE_O  = 2'b00;
  assign API_LOCK_O = 1'b0;

  always_comb begin
    term  = wait_ph && (API_ACK_I || API_ERR_I);
    rx_go = (state == S_RX) && !wait_ph && (rx_credit != '0) && !nonce_valid;
    tx_go = (state == S_TX) && !wait_ph && (tx_credit != '0) && work_valid;
    issue = rx_go || tx_go ||
            (!wait_ph && (state inside {S_CFG_TO, S_CFG_SCK, S_FLUSH, S_POLL}));
  end

  // Ready is only offered in the TX issue cycle, so the word lands in DAT_O.
  assign work_ready = tx_go && !rst;

  api_master_watchdog #(.TIMEOUT(ACK_TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .start   (issue),
    .clear   (term),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_ph     <= 1'b0;
      stb         <= 1'b0;
      we          <= 1'b0;
      adr         <= '0;
      dat_o       <= '0;
      rx_credit   <= '0;
      tx_credit   <= '0;
      consumed    <= 1'b0;
      flush_pend  <= 1'b0;
      cfg_pend    <= 1'b0;
      cfg_to_q    <= '0;
      cfg_sck_q   <= '0;
      gap_cnt     <= '0;
      nonce_valid <= 1'b0;
      nonce_data  <= '0;
      bus_err     <= 1'b0;
      api_state   <= '0;
    end else begin
      if (flush_req) flush_pend <= 1'b1;
      if (cfg_req) begin
        cfg_pend  <= 1'b1;
        cfg_to_q  <= cfg_timeout;
        cfg_sck_q <= cfg_sck;
      end
      if (nonce_valid && nonce_ready) nonce_valid <= 1'b0;

      if (wait_ph) begin
        if (term) begin
          stb     <= 1'b0;
          wait_ph <= 1'b0;
          if (API_ERR_I) bus_err <= 1'b1;
          case (state)
            S_CFG_TO:  state <= S_CFG_SCK;
            S_CFG_SCK: state <= S_IDLE;
            S_FLUSH:   state <= S_POLL;
            S_POLL: begin
              state <= S_RX;
              if (API_ERR_I) begin
                rx_credit <= '0;
                tx_credit <= '0;
              end else begin
                api_state <= API_DAT_I;
                rx_credit <= rd_sw.rxcnt;
                tx_credit <= calc_tx_credit(rd_sw, TX_DEPTH);
              end
            end
            S_RX: begin
              rx_credit <= rx_credit - 1'b1;
              consumed  <= 1'b1;
              if (!API_ERR_I) begin
                nonce_data  <= API_DAT_I;
                nonce_valid <= 1'b1;
              end
            end
            S_TX: begin
              tx_credit <= tx_credit - 1'b1;
              consumed  <= 1'b1;
            end
            default: state <= S_IDLE;
          endcase
        end else if (wd_expired) begin
          stb     <= 1'b0;
          wait_ph <= 1'b0;
          bus_err <= 1'b1;
          state   <= S_IDLE;
        end
      end else begin
        case (state)
          S_IDLE: begin
            // A request landing in the dispatch cycle stays pending for later.
            if (flush_pend) begin
              state      <= S_FLUSH;
              flush_pend <= flush_req;
            end else if (cfg_pend) begin
              state    <= S_CFG_TO;
              cfg_pend <= cfg_req;
            end else begin
              state <= S_POLL;
            end
          end
          S_CFG_TO: begin
            stb <= 1'b1; wait_ph <= 1'b1; we <= 1'b1;
            adr   <= ADR_TIMEOUT;
            dat_o <= {7'b0, cfg_to_q};
          end
          S_CFG_SCK: begin
            stb <= 1'b1; wait_ph <= 1'b1; we <= 1'b1;
            adr   <= ADR_SCK;
            dat_o <= cfg_sck_q;
          end
          S_FLUSH: begin
            stb <= 1'b1; wait_ph <= 1'b1; we <= 1'b1;
            adr   <= ADR_STATE;
            dat_o <= FLUSH_WORD;
          end
          S_POLL: begin
            stb <= 1'b1; wait_ph <= 1'b1; we <= 1'b0;
            adr      <= ADR_STATE;
            consumed <= 1'b0;
          end
          S_RX: begin
            if (rx_credit == '0) begin
              state <= S_TX;
            end else if (rx_go) begin
              stb <= 1'b1; wait_ph <= 1'b1; we <= 1'b0;
              adr <= ADR_RXFIFO;
            end
          end
          S_TX: begin
            if (tx_go) begin
              stb <= 1'b1; wait_ph <= 1'b1; we <= 1'b1;
              adr   <= ADR_TXFIFO;
              dat_o <= work_data;
            end else if (consumed) begin
              state <= S_IDLE;
            end else begin
              state   <= S_GAP;
              gap_cnt <= '0;
            end
          end
          S_GAP: begin
            if (gap_cnt == 8'(POLL_GAP - 1)) state <= S_IDLE;
            else                             gap_cnt <= gap_cnt + 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_api_master.sv
// Directed bench for api_master: Wishbone slave model, bus transaction log,
// work source and nonce sink; checks are immediate assertions.
module tb_api_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        API_CYC_O, API_STB_O, API_WE_O, API_LOCK_O;
  logic [5:0]  API_ADR_O;
  logic [31:0] API_DAT_O;
  logic [3:0]  API_SEL_O;
  logic [2:0]  API_CTI_O;
  logic [1:0]  API_BTE_O;
  logic        API_ACK_I, API_ERR_I, API_RTY_I;
  logic [31:0] API_DAT_I;
  logic        work_valid, work_ready;
  logic [31:0] work_data;
  logic        nonce_valid, nonce_ready;
  logic [31:0] nonce_data;
  logic        cfg_req, flush_req, bus_err;
  logic [24:0] cfg_timeout;
  logic [31:0] cfg_sck, api_state;

  api_master dut (
    .clk(clk), .rst(rst),
    .API_CYC_O(API_CYC_O), .API_STB_O(API_STB_O), .API_WE_O(API_WE_O),
    .API_ADR_O(API_ADR_O), .API_DAT_O(API_DAT_O), .API_SEL_O(API_SEL_O),
    .API_CTI_O(API_CTI_O), .API_BTE_O(API_BTE_O), .API_LOCK_O(API_LOCK_O),
    .API_ACK_I(API_ACK_I), .API_ERR_I(API_ERR_I), .API_RTY_I(API_RTY_I),
    .API_DAT_I(API_DAT_I),
    .work_valid(work_valid), .work_ready(work_ready), .work_data(work_data),
    .nonce_valid(nonce_valid), .nonce_ready(nonce_ready), .nonce_data(nonce_data),
    .cfg_req(cfg_req), .cfg_timeout(cfg_timeout), .cfg_sck(cfg_sck),
    .flush_req(flush_req), .bus_err(bus_err), .api_state(api_state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Slave: mode 0 = ACK all, 1 = never terminate, 3 = ACK STATE / ERR RXFIFO
  int          slv_mode;
  logic [31:0] slv_state;
  int          rx_idx;

  assign API_RTY_I = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      API_ACK_I <= 1'b0; API_ERR_I <= 1'b0; API_DAT_I <= '0; rx_idx <= 0;
    end else if (API_STB_O && !API_ACK_I && !API_ERR_I) begin
      if (slv_mode == 0 || (slv_mode == 3 && API_ADR_O != 6'h04)) begin
        API_ACK_I <= 1'b1;
        if (API_ADR_O == 6'h08) API_DAT_I <= slv_state;
        else if (API_ADR_O == 6'h04) begin
          API_DAT_I <= 32'hA500_0000 + 32'(rx_idx);
          rx_idx    <= rx_idx + 1;
        end else API_DAT_I <= '0;
      end else if (slv_mode == 3) begin
        API_ERR_I <= 1'b1;
      end
    end else begin
      API_ACK_I <= 1'b0; API_ERR_I <= 1'b0;
    end
  end

  // Work source
  logic [31:0] w_arr [0:7];
  int          w_n;
  int          w_idx;
  int          rdy_cnt;
  logic        hs_w;

  always @(posedge clk) begin
    hs_w = work_valid && work_ready;
    #1;
    if (rst) begin
      w_idx = 0; rdy_cnt = 0;
    end else if (hs_w) begin
      w_idx++; rdy_cnt++;
    end
    work_valid = !rst && (w_idx < w_n);
    work_data  = (w_idx < w_n) ? w_arr[w_idx] : 32'h0;
  end

  // Bus/nonce monitor sampled on the falling edge
  typedef struct {
    logic [5:0]  adr;
    logic        we;
    logic [31:0] dat;
    int          st;
  } xact_t;

  xact_t       xq[$];
  int          lq[$];
  logic [31:0] nq[$];
  int          cyc = 0;
  int          cur_len;
  logic        stb_prev;
  logic        nv_seen;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      xq.delete(); lq.delete(); nq.delete();
      stb_prev = 1'b0; cur_len = 0; nv_seen = 1'b0;
    end else begin
      if (API_STB_O && !stb_prev) begin
        xact_t x;
        x.adr = API_ADR_O; x.we = API_WE_O; x.dat = API_DAT_O; x.st = cyc;
        xq.push_back(x);
        cur_len = 1;
      end else if (API_STB_O) begin
        cur_len++;
      end else if (stb_prev) begin
        lq.push_back(cur_len);
      end
      stb_prev = API_STB_O;
      if (nonce_valid) nv_seen = 1'b1;
      if (nonce_valid && nonce_ready) nq.push_back(nonce_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int find_x(input logic [5:0] a, input logic w, input int from);
    for (int i = from; i < xq.size(); i++)
      if (xq[i].adr == a && xq[i].we == w) return i;
    return -1;
  endfunction

  function automatic int count_x(input logic [5:0] a, input logic w, input int upto);
    int n = 0;
    for (int i = 0; i < upto && i < xq.size(); i++)
      if (xq[i].adr == a && xq[i].we == w) n++;
    return n;
  endfunction

  task automatic wait_x(input logic [5:0] a, input logic w, input int n, input int budget,
                        input string tag);
    int t = 0;
    while (count_x(a, w, xq.size()) < n && t < budget) begin
      @(negedge clk); t++;
    end
    check(tag, 32'(count_x(a, w, xq.size()) >= n), 32'd1);
  endtask

  task automatic start_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  int k, f, rdy_cyc;

  initial begin
    rst = 1'b1; slv_mode = 0; slv_state = '0; w_n = 0;
    nonce_ready = 1'b0; cfg_req = 1'b0; flush_req = 1'b0;
    cfg_timeout = '0; cfg_sck = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_stb",    32'(API_STB_O),   32'd0);
    check("rst_cyc",    32'(API_CYC_O),   32'd0);
    check("rst_adr",    32'(API_ADR_O),   32'd0);
    check("rst_dat",    API_DAT_O,        32'd0);
    check("rst_wready", 32'(work_ready),  32'd0);
    check("rst_nvalid", 32'(nonce_valid), 32'd0);
    check("rst_ndata",  nonce_data,       32'd0);
    check("rst_state",  api_state,        32'd0);
    check("rst_buserr", 32'(bus_err),     32'd0);
    check("rst_sel",    32'(API_SEL_O),   32'hf);

    // Three work words into an empty TXFIFO
    w_arr[0] = 32'hDEAD_0001; w_arr[1] = 32'hBEEF_0002; w_arr[2] = 32'hCAFE_0003;
    w_n = 3; slv_state = 32'h0;
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("t1_nxact", 32'(xq.size() >= 4), 32'd1);
    if (xq.size() >= 4 && lq.size() >= 4) begin
      check("t1_poll_adr", 32'(xq[0].adr), 32'h08);
      check("t1_poll_we",  32'(xq[0].we),  32'd0);
      for (int i = 1; i <= 3; i++) begin
        check($sformatf("t1_w%0d_adr", i), 32'(xq[i].adr), 32'h00);
        check($sformatf("t1_w%0d_we", i),  32'(xq[i].we),  32'd1);
        check($sformatf("t1_w%0d_dat", i), xq[i].dat,      w_arr[i-1]);
        check($sformatf("t1_w%0d_len", i), 32'(lq[i]),     32'd2);
      end
      check("t1_spacing12", 32'(xq[2].st - xq[1].st), 32'd3);
      check("t1_spacing23", 32'(xq[3].st - xq[2].st), 32'd3);
    end
    check("t1_ready_pulses", 32'(rdy_cnt), 32'd3);

    // TX full: no write, repoll after the gap, then drain once space appears
    start_reset();
    w_arr[0] = 32'h1234_5678; w_n = 1; slv_state = 32'h0000_0001;
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("t2_no_txwrite", 32'(count_x(6'h00, 1'b1, xq.size())), 32'd0);
    check("t2_api_state",  api_state, 32'h0000_0001);
    if (xq.size() >= 2) begin
      check("t2_repoll_adr", 32'(xq[1].adr), 32'h08);
      check("t2_repoll_gap", 32'(xq[1].st - xq[0].st), 32'd10);
    end else check("t2_repoll_seen", 32'(xq.size()), 32'd2);
    slv_state = 32'h0;
    wait_x(6'h00, 1'b1, 1, 40, "t2_txwrite_seen");
    k = find_x(6'h00, 1'b1, 0);
    if (k >= 0) check("t2_txwrite_dat", xq[k].dat, 32'h1234_5678);
    check("t2_ready_pulses", 32'(rdy_cnt), 32'd1);

    // RX with two words and a stalled consumer
    start_reset();
    w_n = 0; slv_state = (32'd2 << 20) | 32'h1; nonce_ready = 1'b0;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t3_one_read",  32'(count_x(6'h04, 1'b0, xq.size())), 32'd1);
    check("t3_nvalid",    32'(nonce_valid), 32'd1);
    check("t3_ndata",     nonce_data, 32'hA500_0000);
    rdy_cyc = cyc;
    nonce_ready = 1'b1;
    wait_x(6'h04, 1'b0, 2, 30, "t3_second_read");
    k = find_x(6'h04, 1'b0, find_x(6'h04, 1'b0, 0) + 1);
    if (k >= 0) check("t3_second_after_accept", 32'(xq[k].st > rdy_cyc), 32'd1);
    repeat (5) @(negedge clk);
    check("t3_nq_size", 32'(nq.size() >= 2), 32'd1);
    if (nq.size() >= 2) begin
      check("t3_nonce0", nq[0], 32'hA500_0000);
      check("t3_nonce1", nq[1], 32'hA500_0001);
    end
    nonce_ready = 1'b0;

    // Config writes ahead of the next poll
    start_reset();
    slv_state = 32'h1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    cfg_timeout = 25'h1ABCDEF; cfg_sck = 32'h0A05_0010; cfg_req = 1'b1;
    @(negedge clk);
    cfg_req = 1'b0;
    wait_x(6'h10, 1'b1, 1, 60, "t4_sck_seen");
    repeat (10) @(negedge clk);
    k = find_x(6'h0c, 1'b1, 0);
    check("t4_to_seen", 32'(k >= 0 && k + 2 < xq.size()), 32'd1);
    if (k >= 0 && k + 2 < xq.size()) begin
      check("t4_to_dat",   xq[k].dat,         32'h01AB_CDEF);
      check("t4_sck_adr",  32'(xq[k+1].adr),  32'h10);
      check("t4_sck_dat",  xq[k+1].dat,       32'h0A05_0010);
      check("t4_poll_adr", 32'(xq[k+2].adr),  32'h08);
      check("t4_poll_we",  32'(xq[k+2].we),   32'd0);
    end

    // Flush requested mid TX round
    start_reset();
    w_arr[0] = 32'h1111_1111; w_arr[1] = 32'h2222_2222; w_arr[2] = 32'h3333_3333;
    w_n = 3; slv_state = 32'h0;
    rst = 1'b0;
    wait_x(6'h00, 1'b1, 1, 40, "t5_first_tx");
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    wait_x(6'h08, 1'b1, 1, 60, "t5_flush_seen");
    repeat (10) @(negedge clk);
    f = find_x(6'h08, 1'b1, 0);
    check("t5_flush_ctx", 32'(f >= 1 && f + 1 < xq.size()), 32'd1);
    if (f >= 1 && f + 1 < xq.size()) begin
      check("t5_tx_before", 32'(count_x(6'h00, 1'b1, f)), 32'd3);
      check("t5_last_tx",   xq[f-1].dat,        32'h3333_3333);
      check("t5_flush_dat", xq[f].dat,          32'h0000_0002);
      check("t5_poll_adr",  32'(xq[f+1].adr),   32'h08);
      check("t5_poll_we",   32'(xq[f+1].we),    32'd0);
    end

    // Slave never answers
    start_reset();
    w_n = 0; slv_mode = 1; slv_state = 32'h0;
    rst = 1'b0;
    repeat (45) @(negedge clk);
    check("t6_bus_err", 32'(bus_err), 32'd1);
    if (xq.size() >= 2 && lq.size() >= 1) begin
      check("t6_stb_len",   32'(lq[0]),               32'd15);
      check("t6_restart",   32'(xq[1].st - xq[0].st), 32'd17);
    end else check("t6_xacts", 32'(xq.size()), 32'd2);

    // ERR on RXFIFO read
    start_reset();
    slv_mode = 3; slv_state = (32'd2 << 20) | 32'h1; nonce_ready = 1'b0;
    rst = 1'b0;
    check("t7_err_clear", 32'(bus_err), 32'd0);
    repeat (40) @(negedge clk);
    check("t7_bus_err",   32'(bus_err), 32'd1);
    check("t7_no_nvalid", 32'(nv_seen), 32'd0);
    check("t7_ndata",     nonce_data,   32'd0);
    check("t7_rx_reads",  32'(count_x(6'h04, 1'b0, xq.size()) >= 2), 32'd1);
    k = find_x(6'h04, 1'b0, 0);
    if (k >= 0 && k < lq.size()) check("t7_err_len", 32'(lq[k]), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
